// File: rtl/inst_fetcher.sv
// Instruction fetch front end: PC, single-outstanding icache requests, predecode, 4-deep in-order queue.
// Optional IF_JAL_PREDICT_EN: redirect JAL locally; otherwise JAL stalls like JALR until the decoder resolves it.
module inst_fetcher #(
  parameter int          IQ_BITS  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        wrong_predicted,
  input  logic [31:0] correct_pc,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_req_ready,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_inst,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  input  logic        issue_signal,
  input  logic [31:0] dec_next_pc
);

  localparam int DEPTH = 1 << IQ_BITS;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_JSTALL, S_DROP} state_t;

  state_t             state, state_d;
  logic [31:0]        pc, pc_d, req_pc, req_pc_d;
  logic               jalr_pending, jalr_pending_d;
  logic [IQ_BITS-1:0] head, tail;
  logic [IQ_BITS:0]   count, count_d;
  logic [31:0]        q_pc   [DEPTH];
  logic [31:0]        q_inst [DEPTH];
  logic               push, pop, req_fire, req_valid_d;
  logic               stall_op_resp, stall_op_head;
  logic [6:0]         resp_op, head_op;

  assign valid     = (count != '0);
  assign inst      = valid ? q_inst[head] : '0;
  assign inst_addr = valid ? q_pc[head] : '0;
  assign resp_op   = ic_resp_inst[6:0];
  assign head_op   = inst[6:0];

`ifdef IF_JAL_PREDICT_EN
  logic [31:0] j_imm;
  assign j_imm = {{11{ic_resp_inst[31]}}, ic_resp_inst[31], ic_resp_inst[19:12],
                  ic_resp_inst[20], ic_resp_inst[30:21], 1'b0};
  assign stall_op_resp = (resp_op == OP_JALR);
  assign stall_op_head = (head_op == OP_JALR);
`else
  assign stall_op_resp = (resp_op == OP_JALR) || (resp_op == OP_JAL);
  assign stall_op_head = (head_op == OP_JALR) || (head_op == OP_JAL);
`endif

  always_comb begin
    state_d        = state;
    pc_d           = pc;
    req_pc_d       = req_pc;
    jalr_pending_d = jalr_pending;
    push           = 1'b0;
    pop            = issue_signal && valid;
    req_fire       = 1'b0;
    case (state)
      S_FETCH: begin
        if (ic_req_valid && ic_req_ready) begin
          req_fire = 1'b1;
          req_pc_d = pc;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ic_resp_valid) begin
          push = 1'b1;
          if (stall_op_resp) begin
            jalr_pending_d = 1'b1;
            state_d        = S_JSTALL;
          end else begin
            pc_d = req_pc + 32'd4;
`ifdef IF_JAL_PREDICT_EN
            if (resp_op == OP_JAL) pc_d = req_pc + j_imm;
`endif
            state_d = S_FETCH;
          end
        end
      end
      S_JSTALL: begin
        if (jalr_pending && pop && stall_op_head) begin
          pc_d           = dec_next_pc;
          jalr_pending_d = 1'b0;
          state_d        = S_FETCH;
        end
      end
      default: begin
        if (ic_resp_valid) state_d = S_FETCH;
      end
    endcase
    if (wrong_predicted) begin
      push           = 1'b0;
      pop            = 1'b0;
      pc_d           = correct_pc;
      jalr_pending_d = 1'b0;
      // A request accepted in the flush cycle still owes a response, so it must be dropped too.
      if (((state == S_WAIT || state == S_DROP) && !ic_resp_valid) || req_fire)
        state_d = S_DROP;
      else
        state_d = S_FETCH;
    end
    count_d = wrong_predicted ? '0
            : count + (IQ_BITS+1)'(push) - (IQ_BITS+1)'(pop);
    req_valid_d = !wrong_predicted && (state_d == S_FETCH)
                  && (count_d < (IQ_BITS+1)'(DEPTH));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      req_pc       <= '0;
      jalr_pending <= 1'b0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ic_req_valid <= 1'b0;
      ic_req_addr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (rdy_in) begin
      state        <= state_d;
      pc           <= pc_d;
      req_pc       <= req_pc_d;
      jalr_pending <= jalr_pending_d;
      count        <= count_d;
      ic_req_valid <= req_valid_d;
      ic_req_addr  <= pc_d;
      if (push) begin
        q_pc[tail]   <= req_pc;
        q_inst[tail] <= ic_resp_inst;
      end
      if (wrong_predicted) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + IQ_BITS'(1);
        if (pop)  head <= head + IQ_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: predecode vector table, directed corner sequences, and randomized
// icache/decoder traffic checked against an architectural next-PC trace model.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, wrong_predicted, ic_req_ready, ic_resp_valid, issue_signal;
  logic [31:0] correct_pc, ic_resp_inst, dec_next_pc;
  logic        ic_req_valid, valid;
  logic [31:0] ic_req_addr, inst, inst_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus knobs
  int p_ready, p_issue, p_flush, p_rdy_low, max_lat;
  bit hold_resp, force_flush;
  logic [31:0] flush_tgt;

  // reference state
  logic [31:0] exp_pc;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_log[$];
  int delivered, pops;

`ifdef IF_JAL_PREDICT_EN
  localparam bit JAL_STALL = 1'b0;
`else
  localparam bit JAL_STALL = 1'b1;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] dec_pc;
    logic [31:0] next;
    bit          stall;
  } vec_t;
  vec_t vecs[7];

  inst_fetcher dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .wrong_predicted(wrong_predicted), .correct_pc(correct_pc),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
    .valid(valid), .inst(inst), .inst_addr(inst_addr),
    .issue_signal(issue_signal), .dec_next_pc(dec_next_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Program image: addresses below 0x1000 are straight-line addi; above, a hashed mix.
  function automatic int kind(input logic [31:0] a);
    logic [31:0] sel;
    if (a < 32'h1000) return 3;
    sel = ((a >> 2) * 7 + (a >> 8)) % 11;
    return (sel < 3) ? int'(sel) : 3;
  endfunction

  function automatic logic [31:0] jal_off(input logic [31:0] a);
    logic [31:0] k;
    k = ((a >> 2) % 7) + 1;
    return a[6] ? -(k * 12) : k * 20;
  endfunction

  function automatic logic [31:0] enc_jal(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] jalr_tgt(input logic [31:0] a);
    return ((a ^ 32'h0000_5a40) | 32'h0000_1000) & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (kind(a))
      0:       return enc_jal(jal_off(a));
      1:       return 32'h0000_8067;
      2:       return 32'h0020_8063;
      default: return {a[13:2], 5'd1, 3'b000, 5'd1, 7'b0010011};
    endcase
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] a);
    case (kind(a))
      0:       return a + jal_off(a);
      1:       return jalr_tgt(a);
      default: return a + 32'd4;
    endcase
  endfunction

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; wrong_predicted = 1'b0; correct_pc = '0;
    ic_req_ready = 1'b0; ic_resp_valid = 1'b0; ic_resp_inst = '0;
    issue_signal = 1'b0; dec_next_pc = '0;
    pend_addr.delete(); pend_due.delete(); acc_log.delete();
    exp_pc = 32'h0; delivered = 0; pops = 0;
    hold_resp = 1'b0; force_flush = 1'b0; flush_tgt = '0;
    repeat (2) @(negedge clk_in);
    check("rst_req_valid", {31'd0, ic_req_valid}, 32'd0);
    check("rst_req_addr", ic_req_addr, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_addr", inst_addr, 32'd0);
    rst_in = 1'b0;
  endtask

  // One cycle of icache + decoder behaviour, called just after a falling edge.
  task automatic step();
    bit rdy, flush, deliver, accept, pop;
    rdy = ($urandom_range(99) >= p_rdy_low);
    checks++;
    if (ic_req_valid && pend_addr.size() != 0) begin
      errors++;
      $display("FAIL one_outstanding: got req_valid 1 with %0d pending, want 0", pend_addr.size());
    end
    deliver = rdy && !hold_resp && pend_addr.size() != 0;
    if (deliver) deliver = (pend_due[0] <= cyc);
    ic_resp_valid = deliver;
    ic_resp_inst  = '0;
    if (deliver) begin
      ic_resp_inst = imem(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      delivered++;
    end
    ic_req_ready = ($urandom_range(99) < p_ready);
    accept = rdy && ic_req_valid && ic_req_ready;
    if (accept) begin
      pend_addr.push_back(ic_req_addr);
      pend_due.push_back(cyc + 1 + int'($urandom_range(max_lat)));
      acc_log.push_back(ic_req_addr);
    end
    flush = force_flush || (p_flush > 0 && $urandom_range(999) < p_flush);
    wrong_predicted = flush;
    correct_pc = force_flush ? flush_tgt
               : ($urandom_range(15) == 0) ? 32'hFFFF_FFF0
               : (($urandom() & 32'h000F_FFFC) | 32'h0000_1000);
    issue_signal = ($urandom_range(99) < p_issue);
    dec_next_pc  = next_pc(exp_pc);
    pop = rdy && issue_signal && valid && !flush;
    if (pop) begin
      check("trace_addr", inst_addr, exp_pc);
      check("trace_inst", inst, imem(exp_pc));
      exp_pc = next_pc(exp_pc);
      pops++;
    end
    if (rdy && flush) exp_pc = correct_pc;
    rdy_in = rdy;
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 8 && !ic_req_valid; i++) @(negedge clk_in);
    check(name, {31'd0, ic_req_valid}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    rdy_in = 1'b1; issue_signal = 1'b0; ic_req_ready = 1'b0; ic_resp_valid = 1'b0;
    wrong_predicted = 1'b1; correct_pc = v.pc;
    @(negedge clk_in);
    wrong_predicted = 1'b0;
    wait_req($sformatf("v%0d_req_seen", idx));
    check($sformatf("v%0d_req_addr", idx), ic_req_addr, v.pc);
    ic_req_ready = 1'b1;
    @(negedge clk_in);
    ic_req_ready = 1'b0;
    check($sformatf("v%0d_wait_idle", idx), {31'd0, ic_req_valid}, 32'd0);
    ic_resp_valid = 1'b1; ic_resp_inst = v.word;
    @(negedge clk_in);
    ic_resp_valid = 1'b0; ic_resp_inst = '0;
    check($sformatf("v%0d_head_addr", idx), inst_addr, v.pc);
    check($sformatf("v%0d_head_inst", idx), inst, v.word);
    if (!v.stall) begin
      check($sformatf("v%0d_next_valid", idx), {31'd0, ic_req_valid}, 32'd1);
      check($sformatf("v%0d_next_addr", idx), ic_req_addr, v.next);
    end else begin
      repeat (5) begin
        check($sformatf("v%0d_stall_idle", idx), {31'd0, ic_req_valid}, 32'd0);
        @(negedge clk_in);
      end
      issue_signal = 1'b1; dec_next_pc = v.dec_pc;
      @(negedge clk_in);
      issue_signal = 1'b0;
      check($sformatf("v%0d_popped", idx), {31'd0, valid}, 32'd0);
      wait_req($sformatf("v%0d_resume_seen", idx));
      check($sformatf("v%0d_resume_addr", idx), ic_req_addr, v.next);
    end
  endtask

  initial begin
    logic        s_rv;
    logic [31:0] s_ra, s_i, s_ia;
    logic        s_v;

    vecs[0] = '{32'h0000_1000, 32'h0010_0093, 32'h0,   32'h0000_1004, 1'b0};
    vecs[1] = '{32'h0000_2000, 32'h0020_8063, 32'h0,   32'h0000_2004, 1'b0};
    vecs[2] = '{32'h0000_0020, 32'h1000_006F, 32'h120, 32'h0000_0120, JAL_STALL};
    vecs[3] = '{32'h0000_0100, 32'hFF9F_F06F, 32'hF8,  32'h0000_00F8, JAL_STALL};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0080_006F, 32'h4,   32'h0000_0004, JAL_STALL};
    vecs[5] = '{32'h0000_0040, 32'h0000_8067, 32'h300, 32'h0000_0300, 1'b1};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0010_0093, 32'h0,   32'h0000_0000, 1'b0};

    p_ready = 100; p_issue = 100; p_flush = 0; p_rdy_low = 0; max_lat = 0;
    do_reset();
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // sequential fetch with decoder always issuing
    do_reset();
    repeat (12) step();
    check("seq_req_count", {31'd0, acc_log.size() >= 3}, 32'd1);
    if (acc_log.size() >= 3) begin
      check("seq_req0", acc_log[0], 32'h0);
      check("seq_req1", acc_log[1], 32'h4);
      check("seq_req2", acc_log[2], 32'h8);
    end
    check("seq_pops", {31'd0, pops >= 3}, 32'd1);

    // queue fills to 4 and then throttles requests
    do_reset();
    p_issue = 0;
    repeat (20) step();
    check("full_pushes", delivered, 32'd4);
    check("full_req_low", {31'd0, ic_req_valid}, 32'd0);
    check("full_valid", {31'd0, valid}, 32'd1);
    acc_log.delete();
    p_issue = 100; step(); p_issue = 0;
    for (int i = 0; i < 10 && acc_log.size() == 0; i++) step();
    check("full_refill_seen", acc_log.size(), 32'd1);
    if (acc_log.size() != 0) check("full_refill_addr", acc_log[0], 32'h10);

    // flush while waiting with 3 entries queued; the late response must be dropped
    do_reset();
    p_issue = 0;
    for (int i = 0; i < 40 && delivered < 3; i++) step();
    hold_resp = 1'b1;
    for (int i = 0; i < 10 && pend_addr.size() != 1; i++) step();
    check("flush_outstanding", pend_addr.size(), 32'd1);
    check("flush_pre_valid", {31'd0, valid}, 32'd1);
    force_flush = 1'b1; flush_tgt = 32'h500;
    step();
    force_flush = 1'b0;
    check("flush_valid_low", {31'd0, valid}, 32'd0);
    acc_log.delete();
    hold_resp = 1'b0; p_issue = 100;
    for (int i = 0; i < 20 && acc_log.size() == 0; i++) step();
    check("flush_req_seen", {31'd0, acc_log.size() != 0}, 32'd1);
    if (acc_log.size() != 0) check("flush_req_addr", acc_log[0], 32'h500);
    repeat (6) step();
    check("flush_resumed", {31'd0, pops > 0}, 32'd1);

    // rdy_in low for 3 cycles during WAIT freezes everything
    do_reset();
    p_issue = 0;
    for (int i = 0; i < 20 && delivered < 1; i++) step();
    hold_resp = 1'b1;
    for (int i = 0; i < 10 && pend_addr.size() != 1; i++) step();
    s_rv = ic_req_valid; s_ra = ic_req_addr; s_v = valid; s_i = inst; s_ia = inst_addr;
    check("frz_pre_head", inst_addr, 32'h0);
    p_rdy_low = 100;
    repeat (3) begin
      step();
      check("frz_req_valid", {31'd0, ic_req_valid}, {31'd0, s_rv});
      check("frz_req_addr", ic_req_addr, s_ra);
      check("frz_valid", {31'd0, valid}, {31'd0, s_v});
      check("frz_inst", inst, s_i);
      check("frz_inst_addr", inst_addr, s_ia);
    end
    p_rdy_low = 0; hold_resp = 1'b0; p_issue = 100;
    acc_log.delete();
    repeat (10) step();
    check("frz_resume_seen", {31'd0, acc_log.size() != 0}, 32'd1);
    if (acc_log.size() != 0) check("frz_resume_addr", acc_log[0], 32'h8);
    check("frz_resume_pops", {31'd0, pops >= 2}, 32'd1);

    // randomized traffic against the trace model
    do_reset();
    p_ready = 70; p_issue = 60; p_flush = 15; p_rdy_low = 10; max_lat = 3;
    repeat (4000) step();
    check("rand_progress", {31'd0, pops > 100}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, want finish before 1ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end stage directly upstream of the decoder. Holds the PC and issues one-at-a-time fetch requests to the instruction cache.
- Predecodes each returned word for static next-PC selection and buffers fetched instructions in a small in-order queue.
- Presents the queue head to the decoder as valid/inst/inst_addr and pops on the decoder's issue_signal.
- Redirects on ROB misprediction flush and resumes after JALR resolution using the decoder's next_pc.

Parameters:
IQ_BITS, 2, log2 of instruction-queue depth (depth = 4)
RESET_PC, 32'h0, PC loaded on reset

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global ready; all state frozen when low
wrong_predicted  input  1  ROB flush request
correct_pc  input  32  redirect target on flush
ic_req_valid  output  1  fetch request to icache
ic_req_addr  output  32  fetch address
ic_req_ready  input  1  icache accepts request this cycle
ic_resp_valid  input  1  icache returns instruction (single cycle pulse)
ic_resp_inst  input  32  returned instruction word
valid  output  1  queue head valid, to decoder
inst  output  32  queue head instruction
inst_addr  output  32  queue head PC
issue_signal  input  1  decoder consumed head this cycle
dec_next_pc  input  32  decoder-computed next PC, used for JALR resume

Behaviour:
- Reset (async, rst_in=1): pc=RESET_PC, queue empty, state=FETCH, ic_req_valid=0, ic_req_addr=0, valid=0, inst=0, inst_addr=0.
- rdy_in=0: no state, queue, or PC change; outputs hold.
- Queue: circular, head/tail IQ_BITS wide with wrap, count IQ_BITS+1 wide. Entry = {pc, inst}. valid = (count!=0). inst/inst_addr = head entry, 0 when empty.
- Pop: issue_signal && valid. Push: accepted icache response (not in DROP). Push and pop in the same cycle leave count unchanged.
- FETCH state:
  - ic_req_valid = (count < depth), registered; ic_req_addr = pc.
  - On ic_req_valid && ic_req_ready: latch req_pc=pc, go to WAIT.
  - At most one outstanding request.
- WAIT state: ic_req_valid=0. On ic_resp_valid:
  - Push {req_pc, ic_resp_inst}.
  - Predecode opcode [6:0]:
    - 1101111 (JAL): pc = req_pc + J-imm (sext {inst[31],inst[19:12],inst[20],inst[30:21],0}); go to FETCH.
    - 1100111 (JALR): set jalr_pending; go to JSTALL.
    - Otherwise, including branches (static not-taken): pc = req_pc+4; go to FETCH.
- Queue space: a request is issued only when count<depth. Because the queue is in-order, one outstanding request, and pops only reduce count, the response always fits.
- JSTALL state:
  - No requests.
  - When the popped head is the pending JALR (head opcode 1100111 && issue_signal): pc = dec_next_pc, clear jalr_pending, go to FETCH.
  - The decoder holds issue while the JALR has an operand dependency; this block waits indefinitely.
- Flush (wrong_predicted=1), highest priority over push/pop/redirect:
  - Queue cleared, pc = correct_pc, jalr_pending cleared, ic_req_valid deasserted.
  - If in WAIT (response outstanding, icache cannot abort): go to DROP. Otherwise go to FETCH.
- DROP state: discard the next ic_resp_valid (no push), then go to FETCH. A second flush while in DROP updates pc and stays in DROP.
- Flush and response in the same cycle: the response is dropped and state goes to FETCH, since the outstanding request is retired.
- Arithmetic: all PC math mod 2^32; wrap-around is legal.
- Reset mid-WAIT: state returns to FETCH. A stale icache response after reset is ignored because state≠WAIT.

Optional Feature:
- Macro IF_JAL_PREDICT_EN.
- Defined: JAL redirects in the fetcher as described above.
- Undefined: JAL is handled like JALR. Enter JSTALL and resume from dec_next_pc when the JAL is popped; no J-imm adder is instantiated.

Test Plan:
- Reset, then icache returns addi words at 0,4,8 with issue_signal held 1 -> requests at 0x0,0x4,0x8; decoder sees inst_addr 0,4,8 in order.
- issue_signal=0, 6 sequential words available -> exactly 4 pushes, ic_req_valid low while count=4; one pop -> next request at 0x10.
- JAL at 0x20 with offset +0x100 (macro on) -> next request at 0x120 the cycle after the response. Macro off -> no request until the pop, then fetch from dec_next_pc=0x120.
- JALR at 0x40; issue_signal held 0 for 5 cycles, then 1 with dec_next_pc=0x300 -> no requests during the stall; next ic_req_addr=0x300.
- wrong_predicted with correct_pc=0x500 while in WAIT with 3 entries queued -> valid=0 next cycle; the late response is discarded; next request at 0x500.
- rdy_in=0 for 3 cycles mid-WAIT with ic_resp_valid low -> pc, count, and outputs unchanged; normal operation resumes afterwards.
